buffer_desalojo: RTL

- Eviction/write-back buffer directly upstream of the third-level cache stage.
- Accepts evicted lines from the level above on D_PUSH and queues them in FIFO order.
- Presents the oldest entry to the third level on D_POP as {address, data}.
- Provides a one-cycle registered address search so pending evictions can be forwarded before they drain.

---
 rtl/buffer_desalojo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/buffer_desalojo.sv
// buffer_desalojo: eviction / write-back buffer that sits in front of the L3 stage.
//   Evicted lines are queued in FIFO order. The oldest line is shown
//   combinationally on D_POP (show-ahead). A registered lookup finds the
//   youngest pending line whose address matches Search_Address.
// Ports:
//   CLK, Clear           clock; async active-high reset
//   D_PUSH               {valid, addr, data} from the level above
//   Pop                  consumer has taken the head entry this cycle
//   D_POP, Pop_Valid     head entry {addr, data}; valid flag (= !Empty)
//   Full, Empty, Count   occupancy
//   Search_Address       lookup key, sampled every cycle
//   Search_Hit/_Data     lookup result, one cycle later
//   Overflow, Underflow  sticky error flags for a dropped push or an empty pop

// Per-slot address comparator. It matches only when the slot holds a pending entry.
module buffer_desalojo_match #(
    parameter int ADDR_W = 24
) (
    input  logic              valid,
    input  logic [ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0] search_addr,
    output logic              hit
);
    assign hit = valid && (entry_addr == search_addr);
endmodule

module buffer_desalojo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 64
) (
    input  logic                         CLK,
    input  logic                         Clear,
    input  logic [ADDR_W+DATA_W:0]       D_PUSH,
    input  logic                         Pop,
    output logic [ADDR_W+DATA_W-1:0]     D_POP,
    output logic                         Pop_Valid,
    output logic                         Full,
    output logic                         Empty,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    input  logic [ADDR_W-1:0]            Search_Address,
    output logic                         Search_Hit,
    output logic [DATA_W-1:0]            Search_Data,
    output logic                         Overflow,
    output logic                         Underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               push_v, push_acc, pop_acc;
    entry_t             push_entry;
    logic [DEPTH-1:0]   slot_hit;
    logic               hit_c;
    logic [DATA_W-1:0]  data_c;

    assign push_v     = D_PUSH[ENT_W];
    assign push_entry = D_PUSH[ENT_W-1:0];

    assign Empty     = (count_q == '0);
    assign Full      = (count_q == CNT_W'(DEPTH));
    assign Count     = count_q;
    assign Pop_Valid = !Empty;
    assign D_POP     = Empty ? '0 : mem[rd_ptr];

    assign pop_acc  = Pop && !Empty;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push_acc = push_v && (!Full || pop_acc);

    // Storage is not reset. Entries outside [rd_ptr, rd_ptr+count) are never observed.
    always_ff @(posedge CLK) begin
        if (push_acc) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_v && !push_acc) Overflow  <= 1'b1;
            if (Pop && Empty)        Underflow <= 1'b1;
        end
    end

    // Slot i is pending when its distance from rd_ptr is below count. The
    // comparison uses pre-edge state, so a slot being popped this cycle still
    // matches and a slot being written this cycle does not.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off = PTR_W'(i) - rd_ptr;
        buffer_desalojo_match #(.ADDR_W(ADDR_W)) u_match (
            .valid       (CNT_W'(off) < count_q),
            .entry_addr  (mem[i].addr),
            .search_addr (Search_Address),
            .hit         (slot_hit[i])
        );
    end

    // Walk from oldest to youngest. The last hit wins, so the result is the youngest match.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (slot_hit[idx]) begin
                hit_c  = 1'b1;
                data_c = mem[idx].data;
            end
        end
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            Search_Hit  <= 1'b0;
            Search_Data <= '0;
        end else begin
            Search_Hit  <= hit_c;
            Search_Data <= data_c;
        end
    end
endmodule
